// File: rtl/latency_mc_pkg.sv
// Shared types, default sizes and saturating arithmetic helpers for latency_mc.
package latency_mc_pkg;

   localparam int unsigned DEF_N  = 4;
   localparam int unsigned DEF_W  = 32;
   localparam int unsigned DEF_PW = 8;

   // Widest counter the helpers can handle.
   localparam int unsigned MAXW = 64;

   typedef logic [DEF_W-1:0]  cnt_t;
   typedef logic [DEF_PW-1:0] pend_t;
   typedef logic [MAXW-1:0]   wide_t;
   typedef logic [MAXW:0]     sat_t;   // {sat_flag, sum}

   // Adds a and b, clipping to the all-ones value of a width-bit counter.
   // The top bit of the result is set when clipping occurred.
   function automatic sat_t sat_add(input wide_t a, input wide_t b, input int unsigned width);
      sat_t  sum;
      wide_t lim;
      lim = (width >= MAXW) ? '1 : ((wide_t'(1) << width) - wide_t'(1));
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, lim})
         sat_add = {1'b1, lim};
      else
         sat_add = sum;
   endfunction

   // Saturating increment by the given single-bit amount.
   function automatic sat_t sat_inc(input wide_t a, input logic en, input int unsigned width);
      sat_inc = sat_add(a, wide_t'(en), width);
   endfunction

endpackage

// File: rtl/latency_mc_chan.sv
// One channel of the latency monitor: issue/retire/aggregate counters,
// pending tracker, high-water mark and sticky overflow/underflow flags.
module latency_mc_chan
   import latency_mc_pkg::*;
#(
   parameter int unsigned W  = DEF_W,
   parameter int unsigned PW = DEF_PW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue,
   input  logic          retire,
   input  logic          clear,
   input  logic          freeze,
   output logic [W-1:0]  issue_cnt_r,
   output logic [W-1:0]  retire_cnt_r,
   output logic [W-1:0]  aggregate_cnt_r,
   output logic [PW-1:0] pending_cnt_r,
   output logic [PW-1:0] hwm_r,
   output logic          ovf_r,
   output logic          unf_r
);

   logic          pend_full;
   logic          pend_empty;
   logic          up;
   logic          dn;
   logic          pend_ovf;
   logic          pend_unf;
   logic          retire_ok;
   logic [PW-1:0] pend_w;
   logic [PW-1:0] hwm_w;
   sat_t          iss_sum;
   sat_t          ret_sum;
   sat_t          agg_sum;
   logic          iss_ovf;
   logic          ret_ovf;
   logic          agg_ovf;

   // Next pending value and saturating next-state of every counter.
   always_comb begin
      pend_full  = &pending_cnt_r;
      pend_empty = (pending_cnt_r == '0);
      up         = issue & ~retire;
      dn         = retire & ~issue;
      pend_ovf   = up & pend_full;
      pend_unf   = dn & pend_empty;
      retire_ok  = retire & ~pend_unf;

      pend_w = pending_cnt_r;
      if (up && !pend_full)
         pend_w = pending_cnt_r + PW'(1);
      else if (dn && !pend_empty)
         pend_w = pending_cnt_r - PW'(1);

      hwm_w = (pend_w > hwm_r) ? pend_w : hwm_r;

      iss_sum = sat_inc(wide_t'(issue_cnt_r), issue, W);
      ret_sum = sat_inc(wide_t'(retire_cnt_r), retire_ok, W);
      agg_sum = sat_add(wide_t'(aggregate_cnt_r), wide_t'(pend_w), W);

      // Above bit W only the clip flag can ever be set, so OR-ing the
      // whole upper range yields the flag.
      iss_ovf = |iss_sum[MAXW:W];
      ret_ovf = |ret_sum[MAXW:W];
      agg_ovf = |agg_sum[MAXW:W];
   end

   // Channel state update; clear behaves as a channel-local reset.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         issue_cnt_r     <= '0;
         retire_cnt_r    <= '0;
         aggregate_cnt_r <= '0;
         pending_cnt_r   <= '0;
         hwm_r           <= '0;
         ovf_r           <= 1'b0;
         unf_r           <= 1'b0;
      end else begin
         pending_cnt_r <= pend_w;
         unf_r         <= unf_r | pend_unf;
         ovf_r         <= ovf_r | pend_ovf | (~freeze & (iss_ovf | ret_ovf | agg_ovf));
         if (!freeze) begin
            issue_cnt_r     <= iss_sum[W-1:0];
            retire_cnt_r    <= ret_sum[W-1:0];
            aggregate_cnt_r <= agg_sum[W-1:0];
            hwm_r           <= hwm_w;
         end
      end
   end

endmodule

// File: rtl/latency_mc.sv
// Multi-channel transaction latency monitor: N independent channels whose
// registered outputs are packed channel 0 in the least significant slice.
module latency_mc
   import latency_mc_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   parameter int unsigned W  = DEF_W,
   parameter int unsigned PW = DEF_PW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    issue,
   input  logic [N-1:0]    retire,
   input  logic [N-1:0]    clear,
   input  logic            freeze,
   output logic [N*W-1:0]  issue_cnt_r,
   output logic [N*W-1:0]  retire_cnt_r,
   output logic [N*W-1:0]  aggregate_cnt_r,
   output logic [N*PW-1:0] pending_cnt_r,
   output logic [N*PW-1:0] hwm_r,
   output logic [N-1:0]    ovf_r,
   output logic [N-1:0]    unf_r
);

   if (PW > W || N < 1 || PW < 1 || W > MAXW) begin : g_param_check
      $error("latency_mc: illegal parameters (need N>=1, 1<=PW<=W<=64)");
   end

   logic [W-1:0]  ic  [N];
   logic [W-1:0]  rc  [N];
   logic [W-1:0]  ag  [N];
   logic [PW-1:0] pc  [N];
   logic [PW-1:0] hw  [N];

   for (genvar i = 0; i < N; i++) begin : g_chan
      latency_mc_chan #(
         .W  (W),
         .PW (PW)
      ) u_chan (
         .clk             (clk),
         .rst             (rst),
         .issue           (issue[i]),
         .retire          (retire[i]),
         .clear           (clear[i]),
         .freeze          (freeze),
         .issue_cnt_r     (ic[i]),
         .retire_cnt_r    (rc[i]),
         .aggregate_cnt_r (ag[i]),
         .pending_cnt_r   (pc[i]),
         .hwm_r           (hw[i]),
         .ovf_r           (ovf_r[i]),
         .unf_r           (unf_r[i])
      );
   end

   // Pack per-channel registers onto the flat output buses.
   always_comb begin
      issue_cnt_r     = '0;
      retire_cnt_r    = '0;
      aggregate_cnt_r = '0;
      pending_cnt_r   = '0;
      hwm_r           = '0;
      for (int unsigned i = 0; i < N; i++) begin
         issue_cnt_r[i*W +: W]     = ic[i];
         retire_cnt_r[i*W +: W]    = rc[i];
         aggregate_cnt_r[i*W +: W] = ag[i];
         pending_cnt_r[i*PW +: PW] = pc[i];
         hwm_r[i*PW +: PW]         = hw[i];
      end
   end

endmodule

// File: tb/tb_latency_mc.sv
// Bench for latency_mc: a default-size instance (A: N=4,W=32,PW=8) and a
// tiny instance (B: N=2,W=4,PW=2) that reaches saturation quickly.
module tb_latency_mc;

   logic clk = 1'b0;
   logic rst;

   logic [3:0]   iss_a, ret_a, clr_a;
   logic         frz_a;
   logic [127:0] ic_a, rc_a, ag_a;
   logic [31:0]  pc_a, hw_a;
   logic [3:0]   ov_a, un_a;

   logic [1:0]   iss_b, ret_b, clr_b;
   logic         frz_b;
   logic [7:0]   ic_b, rc_b, ag_b;
   logic [3:0]   pc_b, hw_b;
   logic [1:0]   ov_b, un_b;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   latency_mc #(.N(4), .W(32), .PW(8)) dut_a (
      .clk(clk), .rst(rst), .issue(iss_a), .retire(ret_a), .clear(clr_a), .freeze(frz_a),
      .issue_cnt_r(ic_a), .retire_cnt_r(rc_a), .aggregate_cnt_r(ag_a),
      .pending_cnt_r(pc_a), .hwm_r(hw_a), .ovf_r(ov_a), .unf_r(un_a));

   latency_mc #(.N(2), .W(4), .PW(2)) dut_b (
      .clk(clk), .rst(rst), .issue(iss_b), .retire(ret_b), .clear(clr_b), .freeze(frz_b),
      .issue_cnt_r(ic_b), .retire_cnt_r(rc_b), .aggregate_cnt_r(ag_b),
      .pending_cnt_r(pc_b), .hwm_r(hw_b), .ovf_r(ov_b), .unf_r(un_b));

   // ---------------- reference model: plain integer bookkeeping ----------
   longint m_ic [2][4];
   longint m_rc [2][4];
   longint m_ag [2][4];
   int     m_pc [2][4];
   int     m_hw [2][4];
   bit     m_ov [2][4];
   bit     m_un [2][4];
   longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
   int     pmax [2] = '{255, 3};
   int     nch  [2] = '{4, 2};

   function automatic longint bump(input int d, input int ch, input longint x, input longint amt);
      if (x + amt > cmax[d]) begin
         m_ov[d][ch] = 1'b1;
         return cmax[d];
      end
      return x + amt;
   endfunction

   task automatic mdl_cycle(input int d, input logic [3:0] is, input logic [3:0] rs,
                            input logic [3:0] cl, input logic fz);
      for (int ch = 0; ch < nch[d]; ch++) begin
         if (rst || cl[ch]) begin
            m_ic[d][ch] = 0; m_rc[d][ch] = 0; m_ag[d][ch] = 0;
            m_pc[d][ch] = 0; m_hw[d][ch] = 0; m_ov[d][ch] = 0; m_un[d][ch] = 0;
         end else begin
            int want;
            bit counted;
            want    = m_pc[d][ch] + int'(is[ch]) - int'(rs[ch]);
            counted = rs[ch];
            if (want > pmax[d]) m_ov[d][ch] = 1'b1;
            else if (want < 0) begin m_un[d][ch] = 1'b1; counted = 1'b0; end
            else m_pc[d][ch] = want;
            if (!fz) begin
               m_ic[d][ch] = bump(d, ch, m_ic[d][ch], longint'(is[ch]));
               m_rc[d][ch] = bump(d, ch, m_rc[d][ch], longint'(counted));
               m_ag[d][ch] = bump(d, ch, m_ag[d][ch], longint'(m_pc[d][ch]));
               if (m_pc[d][ch] > m_hw[d][ch]) m_hw[d][ch] = m_pc[d][ch];
            end
         end
      end
   endtask

   // Advance one clock: model consumes the same inputs the DUTs see.
   task automatic step();
      mdl_cycle(0, iss_a, ret_a, clr_a, frz_a);
      mdl_cycle(1, {2'b00, iss_b}, {2'b00, ret_b}, {2'b00, clr_b}, frz_b);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      iss_a = '0; ret_a = '0; clr_a = '0; frz_a = 1'b0;
      iss_b = '0; ret_b = '0; clr_b = '0; frz_b = 1'b0;
   endtask

   task automatic cmp(input string nm, input int d, input int ch,
                      input longint ic, input longint rc, input longint ag,
                      input int pc, input int hw, input bit ov, input bit un);
      longint gic, grc, gag;
      int     gpc, ghw;
      bit     gov, gun;
      if (d == 0) begin
         gic = longint'(ic_a[ch*32 +: 32]); grc = longint'(rc_a[ch*32 +: 32]);
         gag = longint'(ag_a[ch*32 +: 32]);
         gpc = int'(pc_a[ch*8 +: 8]); ghw = int'(hw_a[ch*8 +: 8]);
         gov = ov_a[ch]; gun = un_a[ch];
      end else begin
         gic = longint'(ic_b[ch*4 +: 4]); grc = longint'(rc_b[ch*4 +: 4]);
         gag = longint'(ag_b[ch*4 +: 4]);
         gpc = int'(pc_b[ch*2 +: 2]); ghw = int'(hw_b[ch*2 +: 2]);
         gov = ov_b[ch]; gun = un_b[ch];
      end
      checks++;
      if (gic == ic && grc == rc && gag == ag && gpc == pc && ghw == hw && gov == ov && gun == un)
         passes++;
      else
         $display("FAIL %s dut%0d ch%0d: got ic=%0d rc=%0d ag=%0d pc=%0d hw=%0d ov=%0d un=%0d, expected ic=%0d rc=%0d ag=%0d pc=%0d hw=%0d ov=%0d un=%0d",
                  nm, d, ch, gic, grc, gag, gpc, ghw, gov, gun, ic, rc, ag, pc, hw, ov, un);
   endtask

   task automatic cmp_model(input string nm, input int d);
      for (int ch = 0; ch < nch[d]; ch++)
         cmp(nm, d, ch, m_ic[d][ch], m_rc[d][ch], m_ag[d][ch], m_pc[d][ch], m_hw[d][ch],
             m_ov[d][ch], m_un[d][ch]);
   endtask

   // ---------------- directed vector table for instance A ----------------
   typedef struct {
      logic [3:0] is, rs, cl;
      logic       fz;
      int         ch;
      longint     ic, rc, ag;
      int         pc, hw;
      bit         ov, un;
   } vec_t;

   vec_t vq[$];

   function automatic void v(input logic [3:0] is, input logic [3:0] rs, input logic [3:0] cl,
                             input logic fz, input int ch, input longint ic, input longint rc,
                             input longint ag, input int pc, input int hw, input bit ov, input bit un);
      vec_t r;
      r.is = is; r.rs = rs; r.cl = cl; r.fz = fz; r.ch = ch;
      r.ic = ic; r.rc = rc; r.ag = ag; r.pc = pc; r.hw = hw; r.ov = ov; r.un = un;
      vq.push_back(r);
   endfunction

   initial begin
      rst = 1'b1;
      idle_inputs();

      // ch1: issues on 0,1,2, retires on 5,6,7 -> aggregate 15
      v(4'b0010, 4'b0000, 4'b0000, 0, 1, 1, 0,  1, 1, 1, 0, 0);
      v(4'b0010, 4'b0000, 4'b0000, 0, 1, 2, 0,  3, 2, 2, 0, 0);
      v(4'b0010, 4'b0000, 4'b0000, 0, 1, 3, 0,  6, 3, 3, 0, 0);
      v(4'b0000, 4'b0000, 4'b0000, 0, 1, 3, 0,  9, 3, 3, 0, 0);
      v(4'b0000, 4'b0000, 4'b0000, 0, 1, 3, 0, 12, 3, 3, 0, 0);
      v(4'b0000, 4'b0010, 4'b0000, 0, 1, 3, 1, 14, 2, 3, 0, 0);
      v(4'b0000, 4'b0010, 4'b0000, 0, 1, 3, 2, 15, 1, 3, 0, 0);
      v(4'b0000, 4'b0010, 4'b0000, 0, 1, 3, 3, 15, 0, 3, 0, 0);
      // ch2: same-cycle issue+retire at pending 2
      v(4'b0100, 4'b0000, 4'b0000, 0, 2, 1, 0,  1, 1, 1, 0, 0);
      v(4'b0100, 4'b0000, 4'b0000, 0, 2, 2, 0,  3, 2, 2, 0, 0);
      v(4'b0100, 4'b0100, 4'b0000, 0, 2, 3, 1,  5, 2, 2, 0, 0);
      // ch3: underflow then clear
      v(4'b0000, 4'b1000, 4'b0000, 0, 3, 0, 0,  0, 0, 0, 0, 1);
      v(4'b0000, 4'b0000, 4'b1000, 0, 3, 0, 0,  0, 0, 0, 0, 0);
      // ch0: freeze holds counters while pending still tracks
      v(4'b0001, 4'b0000, 4'b0000, 0, 0, 1, 0,  1, 1, 1, 0, 0);
      v(4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0,  1, 1, 1, 0, 0);
      v(4'b0000, 4'b0001, 4'b0000, 1, 0, 1, 0,  1, 0, 1, 0, 0);
      v(4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0,  1, 0, 1, 0, 0);
      // ch0: clear beats a same-cycle issue
      v(4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0,  0, 0, 0, 0, 0);

      step();
      step();
      for (int ch = 0; ch < 4; ch++) cmp("reset_a", 0, ch, 0, 0, 0, 0, 0, 0, 0);
      for (int ch = 0; ch < 2; ch++) cmp("reset_b", 1, ch, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      foreach (vq[k]) begin
         iss_a = vq[k].is; ret_a = vq[k].rs; clr_a = vq[k].cl; frz_a = vq[k].fz;
         step();
         cmp($sformatf("vec%0d", k), 0, vq[k].ch, vq[k].ic, vq[k].rc, vq[k].ag,
             vq[k].pc, vq[k].hw, vq[k].ov, vq[k].un);
      end
      idle_inputs();

      // Issue at cycle 10, retire at cycle 13 after reset -> aggregate 3
      rst = 1'b1; step(); rst = 1'b0;
      for (int c = 0; c <= 13; c++) begin
         iss_a[0] = (c == 10);
         ret_a[0] = (c == 13);
         step();
      end
      idle_inputs();
      cmp("lat3_ch0", 0, 0, 1, 1, 3, 0, 1, 0, 0);
      for (int ch = 1; ch < 4; ch++) cmp("lat3_idle", 0, ch, 0, 0, 0, 0, 0, 0, 0);

      // Small instance: one transaction open 21 cycles saturates aggregate at 15
      iss_b[0] = 1'b1; step(); iss_b[0] = 1'b0;
      for (int c = 0; c < 20; c++) step();
      cmp("agg_sat", 1, 0, 1, 0, 15, 1, 1, 1, 0);
      // Four back-to-back issues into a 2-bit pending counter
      for (int c = 0; c < 4; c++) begin iss_b[1] = 1'b1; step(); end
      iss_b[1] = 1'b0;
      cmp("pend_sat", 1, 1, 4, 0, 9, 3, 3, 1, 0);

      // Reset in the middle of open transactions, with strobes still active
      iss_a = '1; iss_b = '1; step();
      rst = 1'b1; ret_a = 4'b0101; step();
      rst = 1'b0; idle_inputs();
      for (int ch = 0; ch < 4; ch++) cmp("rst_mid_a", 0, ch, 0, 0, 0, 0, 0, 0, 0);
      for (int ch = 0; ch < 2; ch++) cmp("rst_mid_b", 1, ch, 0, 0, 0, 0, 0, 0, 0);

      // Random traffic on both instances checked against the model every cycle
      for (int c = 0; c < 400; c++) begin
         iss_a = 4'($urandom); ret_a = 4'($urandom);
         iss_b = 2'($urandom); ret_b = 2'($urandom);
         for (int ch = 0; ch < 4; ch++) clr_a[ch] = ($urandom_range(0, 31) == 0);
         for (int ch = 0; ch < 2; ch++) clr_b[ch] = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 9) == 0) frz_a = ~frz_a;
         if ($urandom_range(0, 9) == 0) frz_b = ~frz_b;
         rst = ($urandom_range(0, 199) == 0);
         step();
         cmp_model("rand", 0);
         cmp_model("rand", 1);
      end
      rst = 1'b0;
      idle_inputs();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
